// File: rtl/trace_print_scheduler.sv
// Round-robin scheduler turning Hack PC-change and data-write debug events into ASCII hex trace lines.
// Define TRACE_TIMESTAMP_EN to prefix each line with a 16-bit capture timestamp (17-byte lines).
module trace_print_scheduler #(
    parameter int unsigned DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trace_en,
    input  logic [14:0]       debug_pc,
    input  logic [15:0]       debug_inst,
    input  logic              debug_write_mem,
    input  logic [14:0]       debug_address_mem,
    input  logic [15:0]       debug_out_mem,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [DROP_W-1:0] drop_count,
    output logic              overflow
);

    typedef enum logic {ST_IDLE, ST_SEND} state_e;
    typedef enum logic {GR_PC, GR_MEM} grant_e;

    typedef struct packed {
        logic [14:0] key;
        logic [15:0] val;
`ifdef TRACE_TIMESTAMP_EN
        logic [15:0] ts;
`endif
    } slot_t;

`ifdef TRACE_TIMESTAMP_EN
    localparam logic [4:0] LAST_IDX = 5'd16;
`else
    localparam logic [4:0] LAST_IDX = 5'd11;
`endif

    state_e             state_q, state_d;
    grant_e             last_grant_q, last_grant_d;
    logic [14:0]        pc_last_q;
    logic               pc_vld_q, pc_vld_d;
    logic               mem_vld_q, mem_vld_d;
    slot_t              pc_slot_q, pc_slot_d;
    slot_t              mem_slot_q, mem_slot_d;
    slot_t              line_q, line_d;
    logic               line_mem_q, line_mem_d;
    logic [4:0]         byte_idx_q, byte_idx_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               ovf_q, ovf_d;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0]        ts_q;
`endif

    logic               pc_ev, mem_ev;
    logic               grant_pc, grant_mem;
    logic               pc_drop, mem_drop;
    logic [7:0]         tx_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] k);
        case (k)
            2'd0:    nib = v[15:12];
            2'd1:    nib = v[11:8];
            2'd2:    nib = v[7:4];
            default: nib = v[3:0];
        endcase
    endfunction

    // Body of a line without any timestamp prefix: tag, ' ', key, ' ', value, LF.
    function automatic logic [7:0] field_byte(input logic [4:0] idx, input logic is_mem,
                                              input logic [15:0] key16, input logic [15:0] val);
        logic [4:0] koff;
        logic [4:0] voff;
        koff = idx - 5'd2;
        voff = idx - 5'd7;
        case (idx)
            5'd0:                      field_byte = is_mem ? 8'h57 : 8'h50;
            5'd1, 5'd6:                field_byte = 8'h20;
            5'd2, 5'd3, 5'd4, 5'd5:    field_byte = hex_char(nib(key16, koff[1:0]));
            5'd7, 5'd8, 5'd9, 5'd10:   field_byte = hex_char(nib(val, voff[1:0]));
            5'd11:                     field_byte = 8'h0A;
            default:                   field_byte = 8'h00;
        endcase
    endfunction

    assign pc_ev  = trace_en && (debug_pc != pc_last_q);
    assign mem_ev = trace_en && debug_write_mem;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        line_d       = line_q;
        line_mem_d   = line_mem_q;
        byte_idx_d   = byte_idx_q;
        grant_pc     = 1'b0;
        grant_mem    = 1'b0;
        if (state_q == ST_IDLE) begin
            // Round-robin pointer only moves when both sources contend.
            if (pc_vld_q && mem_vld_q) begin
                if (last_grant_q == GR_MEM) begin
                    grant_pc     = 1'b1;
                    last_grant_d = GR_PC;
                end else begin
                    grant_mem    = 1'b1;
                    last_grant_d = GR_MEM;
                end
            end else if (pc_vld_q) begin
                grant_pc = 1'b1;
            end else if (mem_vld_q) begin
                grant_mem = 1'b1;
            end
            if (grant_pc) begin
                line_d     = pc_slot_q;
                line_mem_d = 1'b0;
                byte_idx_d = '0;
                state_d    = ST_SEND;
            end else if (grant_mem) begin
                line_d     = mem_slot_q;
                line_mem_d = 1'b1;
                byte_idx_d = '0;
                state_d    = ST_SEND;
            end
        end else begin
            if (tx_ready) begin
                if (byte_idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    byte_idx_d = byte_idx_q + 5'd1;
                end
            end
        end
    end

    // A slot being granted this cycle counts as empty, so a same-edge capture is not a drop.
    always_comb begin
        pc_vld_d   = pc_vld_q && !grant_pc;
        pc_slot_d  = pc_slot_q;
        pc_drop    = 1'b0;
        mem_vld_d  = mem_vld_q && !grant_mem;
        mem_slot_d = mem_slot_q;
        mem_drop   = 1'b0;
        if (pc_ev) begin
            if (!pc_vld_q || grant_pc) begin
                pc_vld_d      = 1'b1;
                pc_slot_d.key = debug_pc;
                pc_slot_d.val = debug_inst;
`ifdef TRACE_TIMESTAMP_EN
                pc_slot_d.ts  = ts_q;
`endif
            end else begin
                pc_drop = 1'b1;
            end
        end
        if (mem_ev) begin
            if (!mem_vld_q || grant_mem) begin
                mem_vld_d      = 1'b1;
                mem_slot_d.key = debug_address_mem;
                mem_slot_d.val = debug_out_mem;
`ifdef TRACE_TIMESTAMP_EN
                mem_slot_d.ts  = ts_q;
`endif
            end else begin
                mem_drop = 1'b1;
            end
        end
    end

    always_comb begin
        drop_d = drop_q;
        ovf_d  = ovf_q || pc_drop || mem_drop;
        if (pc_drop && (drop_d != '1)) begin
            drop_d = drop_d + DROP_W'(1);
        end
        if (mem_drop && (drop_d != '1)) begin
            drop_d = drop_d + DROP_W'(1);
        end
    end

    always_comb begin
        tx_byte = 8'h00;
`ifdef TRACE_TIMESTAMP_EN
        if (byte_idx_q < 5'd4) begin
            tx_byte = hex_char(nib(line_q.ts, byte_idx_q[1:0]));
        end else if (byte_idx_q == 5'd4) begin
            tx_byte = 8'h20;
        end else begin
            tx_byte = field_byte(byte_idx_q - 5'd5, line_mem_q, {1'b0, line_q.key}, line_q.val);
        end
`else
        tx_byte = field_byte(byte_idx_q, line_mem_q, {1'b0, line_q.key}, line_q.val);
`endif
    end

    assign tx_valid   = (state_q == ST_SEND);
    assign tx_data    = tx_valid ? tx_byte : 8'h00;
    assign busy       = (state_q != ST_IDLE) || pc_vld_q || mem_vld_q;
    assign drop_count = drop_q;
    assign overflow   = ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GR_MEM;
            pc_last_q    <= '0;
            pc_vld_q     <= 1'b0;
            mem_vld_q    <= 1'b0;
            pc_slot_q    <= '0;
            mem_slot_q   <= '0;
            line_q       <= '0;
            line_mem_q   <= 1'b0;
            byte_idx_q   <= '0;
            drop_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pc_last_q    <= debug_pc;
            pc_vld_q     <= pc_vld_d;
            mem_vld_q    <= mem_vld_d;
            pc_slot_q    <= pc_slot_d;
            mem_slot_q   <= mem_slot_d;
            line_q       <= line_d;
            line_mem_q   <= line_mem_d;
            byte_idx_q   <= byte_idx_d;
            drop_q       <= drop_d;
            ovf_q        <= ovf_d;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_trace_print_scheduler.sv
// Scoreboard bench for trace_print_scheduler: expected line bytes are queued, a monitor checks every accepted byte.
module tb_trace_print_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_en;
    logic [14:0] debug_pc;
    logic [15:0] debug_inst;
    logic        debug_write_mem;
    logic [14:0] debug_address_mem;
    logic [15:0] debug_out_mem;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  drop_count;
    logic        overflow;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned accepted_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_byte;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_data = 8'h00;

    trace_print_scheduler #(.DROP_W(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .trace_en          (trace_en),
        .debug_pc          (debug_pc),
        .debug_inst        (debug_inst),
        .debug_write_mem   (debug_write_mem),
        .debug_address_mem (debug_address_mem),
        .debug_out_mem     (debug_out_mem),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .busy              (busy),
        .drop_count        (drop_count),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_line(input string s);
        for (int i = 0; i < s.len(); i++) begin
            exp_q.push_back(8'(s[i]));
        end
        exp_q.push_back(8'h0A);
    endtask

    task automatic pulse(input logic [14:0] pc, input logic [15:0] inst, input logic wr,
                         input logic [14:0] addr, input logic [15:0] data);
        debug_pc          = pc;
        debug_inst        = inst;
        debug_write_mem   = wr;
        debug_address_mem = addr;
        debug_out_mem     = data;
        @(posedge clk);
        #1;
        debug_write_mem = 1'b0;
    endtask

    task automatic wait_drain(input int unsigned bound);
        bit done;
        done = 1'b0;
        for (int unsigned i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d bytes still pending, busy=%0b, required 0 pending and idle",
                     exp_q.size(), busy);
        end
    endtask

    // Monitor: every accepted byte must match the head of the scoreboard; stalled bytes must hold.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(stall_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_byte: got %0h required no byte", tx_data);
                end else begin
                    exp_byte = exp_q.pop_front();
                    check("line_byte", 32'(tx_data), 32'(exp_byte));
                end
                accepted_cnt++;
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned busy_cycles;
        int unsigned valid_cycles;

        reset             = 1'b1;
        trace_en          = 1'b1;
        tx_ready          = 1'b1;
        debug_pc          = '0;
        debug_inst        = '0;
        debug_write_mem   = 1'b0;
        debug_address_mem = '0;
        debug_out_mem     = '0;
        #2;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single PC line and its latency.
        push_line("P 0010 EC10");
        debug_pc   = 15'h0010;
        debug_inst = 16'hEC10;
        @(negedge clk);
        check("t1_event_busy", 32'(busy), 32'd0);
        check("t1_event_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check("t1_capture_busy", 32'(busy), 32'd1);
        check("t1_capture_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check("t1_first_valid", 32'(tx_valid), 32'd1);
        check("t1_first_byte", 32'(tx_data), 32'h50);
        wait_drain(40);
        check("t1_busy_after", 32'(busy), 32'd0);

        // Simultaneous PC and write: PC wins first tie, one idle cycle between lines.
        @(posedge clk);
        #1;
        push_line("P 0001 1234");
        push_line("W 0000 0007");
        pulse(15'h0001, 16'h1234, 1'b1, 15'h0000, 16'h0007);
        busy_cycles  = 0;
        valid_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cycles++;
            if (tx_valid) valid_cycles++;
        end
        check("t2_busy_cycles", busy_cycles, 32'd26);
        check("t2_valid_cycles", valid_cycles, 32'd24);
        wait_drain(10);

        // Second tie goes to the write.
        @(posedge clk);
        #1;
        push_line("W 7FFF FFFF");
        push_line("P 0002 ABCD");
        pulse(15'h0002, 16'hABCD, 1'b1, 15'h7FFF, 16'hFFFF);
        wait_drain(60);

        // Back-pressure mid-line.
        @(posedge clk);
        #1;
        push_line("P 0003 0F5A");
        pulse(15'h0003, 16'h0F5A, 1'b0, 15'h0000, 16'h0000);
        repeat (4) @(posedge clk);
        #1;
        check("t3_valid_at_stall", 32'(tx_valid), 32'd1);
        tx_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_drain(40);

        // Three writes into a full slot while the transmitter is stalled.
        @(posedge clk);
        #1;
        push_line("P 0004 0000");
        push_line("W 0100 1111");
        tx_ready   = 1'b0;
        debug_pc   = 15'h0004;
        debug_inst = 16'h0000;
        @(posedge clk);
        #1;
        debug_write_mem   = 1'b1;
        debug_address_mem = 15'h0100;
        debug_out_mem     = 16'h1111;
        @(posedge clk);
        #1;
        debug_address_mem = 15'h0101;
        debug_out_mem     = 16'h2222;
        @(posedge clk);
        #1;
        debug_address_mem = 15'h0102;
        debug_out_mem     = 16'h3333;
        @(posedge clk);
        #1;
        debug_write_mem = 1'b0;
        @(negedge clk);
        check("t4_drop_count", 32'(drop_count), 32'd2);
        check("t4_overflow", 32'(overflow), 32'd1);
        check("t4_stalled_byte", 32'(tx_data), 32'h50);
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_drain(60);

        // trace_en low blocks capture and drop counting.
        @(posedge clk);
        #1;
        trace_en = 1'b0;
        pulse(15'h0005, 16'h5555, 1'b1, 15'h0200, 16'h4444);
        repeat (3) @(negedge clk);
        check("t5_busy_disabled", 32'(busy), 32'd0);
        check("t5_valid_disabled", 32'(tx_valid), 32'd0);
        check("t5_drop_unchanged", 32'(drop_count), 32'd2);
        @(posedge clk);
        #1;
        trace_en = 1'b1;
        push_line("P 0006 6006");
        pulse(15'h0006, 16'h6006, 1'b0, 15'h0000, 16'h0000);
        wait_drain(40);

        // Reset while byte 5 is on the wire.
        @(posedge clk);
        #1;
        push_line("P 0007 7777");
        accepted_cnt = 0;
        pulse(15'h0007, 16'h7777, 1'b0, 15'h0000, 16'h0000);
        for (int i = 0; i < 40 && accepted_cnt < 5; i++) begin
            @(negedge clk);
            #1;
        end
        check("t6_reached_byte5", accepted_cnt, 32'd5);
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        check("t6_byte5", 32'(tx_data), 32'h37);
        #1;
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(tx_valid), 32'd0);
        check("t6_rst_data", 32'(tx_data), 32'h00);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_drop", 32'(drop_count), 32'd0);
        check("t6_rst_overflow", 32'(overflow), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        push_line("P 0007 7777");
        reset = 1'b0;
        wait_drain(40);
        check("t6_final_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
